mem_controller: RTL and testbench

- CPU-side memory controller: holds a program-address and a data-address register and drives a 25-bit physical address.
- Sequences single-byte read/write transactions to a downstream serial-memory transaction engine (start/stall/stop handshake).
- Returns read data and a completion pulse to the CPU bus.

---
 rtl/mem_controller_if.sv | 62 ++++++
 rtl/mem_controller.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mem_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_controller_if.sv
// mem_controller_pkg / mem_controller_if
//
// Purpose: shared CPU-side enumerations and the handshake bundle between
// the memory controller and the downstream serial-memory transaction engine.
//
// Interface signals (direction as seen from the controller, modport master):
//   addr_out    out  25   physical address (bit 24 = data space)
//   data_out    out  DW   write byte presented to the engine
//   start_read  out  1    one-cycle read-start pulse
//   start_write out  1    one-cycle write-start pulse
//   stall_txn   out  1    keep the open transaction alive between bytes
//   stop_txn    out  1    one-cycle transaction-end pulse
//   data_in     in   DW   read byte from the engine
//   data_req    in   1    engine has consumed data_out
//   data_ready  in   1    data_in is valid

package mem_controller_pkg;

    typedef enum logic [1:0] {
        ADDR_NOP     = 2'd0,
        ADDR_LOAD_LO = 2'd1,
        ADDR_LOAD_HI = 2'd2,
        ADDR_INC     = 2'd3
    } addr_register_op_e;

    typedef enum logic {
        ADDR_SEL_PC   = 1'b0,
        ADDR_SEL_DATA = 1'b1
    } addr_sel_e;

    // Encoding 3 is left unnamed and is decoded as a no-op.
    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_e;

endpackage

interface mem_controller_if #(
    parameter int DATA_BUS_WIDTH = 8
);
    logic [24:0]               addr_out;
    logic [DATA_BUS_WIDTH-1:0] data_out;
    logic                      start_read;
    logic                      start_write;
    logic                      stall_txn;
    logic                      stop_txn;
    logic [DATA_BUS_WIDTH-1:0] data_in;
    logic                      data_req;
    logic                      data_ready;

    modport master (
        output addr_out, data_out, start_read, start_write, stall_txn, stop_txn,
        input  data_in, data_req, data_ready
    );

    modport slave (
        input  addr_out, data_out, start_read, start_write, stall_txn, stop_txn,
        output data_in, data_req, data_ready
    );
endinterface

// File: rtl/mem_controller.sv
// mem_controller
//
// Purpose: CPU-side memory controller. Keeps a program-address and a
// data-address register, drives a 25-bit physical address and sequences
// single-byte read/write transactions to a serial-memory engine.
//
// Ports:
//   clock        in   1    system clock, rising edge
//   reset        in   1    asynchronous, active-low reset
//   addr_reg_op  in   2    NOP / LOAD_LO / LOAD_HI / INC on the selected register
//   addr_sel     in   1    PC (0) or DATA (1) register select
//   op           in   2    NOP / READ / WRITE (3 = NOP)
//   bus_data_in  in   DW   address byte load value, write data
//   bus_data_out out  DW   last read byte
//   op_done_out  out  1    one-cycle completion pulse
//   eng          mem_controller_if.master  engine handshake bundle
//
// Build option: define MEM_CTRL_BURST_EN to keep a transaction open
// (stall_txn) across sequential same-type, same-register accesses.
// Without it stall_txn is tied low and each access is its own start/stop.
//
// Parameter constraint: DATA_BUS_WIDTH <= ADDRESS_WIDTH <= 2*DATA_BUS_WIDTH,
// ADDRESS_WIDTH <= 24.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no open transaction, waiting for a CPU op
// RD_WAIT  | read started, waiting for data_ready
// WR_WAIT  | write started, waiting for data_req
// ACK      | byte done, waiting for the CPU to drop op to NOP
// HOLD     | (burst build) transaction held open by stall_txn

module mem_controller
    import mem_controller_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int ADDRESS_WIDTH  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  addr_register_op_e         addr_reg_op,
    input  addr_sel_e                 addr_sel,
    input  mem_op_e                   op,
    input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
    output logic [DATA_BUS_WIDTH-1:0] bus_data_out,
    output logic                      op_done_out,
    mem_controller_if.master          eng
);

    localparam int DW = DATA_BUS_WIDTH;
    localparam int AW = ADDRESS_WIDTH;
    localparam logic [AW-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_ACK     = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d, dp_q, dp_d;
    logic [AW-1:0]   sel_reg;
    logic [24:0]     addr_full;
    logic            start_rd_q, start_rd_d;
    logic            start_wr_q, start_wr_d;
    logic            stop_q, stop_d;
    logic            done_q, done_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            is_read, is_write;
`ifdef MEM_CTRL_BURST_EN
    logic            stall_q, stall_d;
    mem_op_e         last_op_q, last_op_d;
    addr_sel_e       last_sel_q, last_sel_d;
    logic [AW-1:0]   last_addr_q, last_addr_d;
    logic            load_on_burst_reg;
    logic            burst_continue;
`endif

    // LOAD_HI is built in a 2*DW window so the high slice is well defined
    // for any AW between DW and 2*DW.
    function automatic logic [AW-1:0] addr_update(
        input logic [AW-1:0]   cur,
        input addr_register_op_e o,
        input logic [DW-1:0]   b
    );
        logic [AW-1:0]   r;
        logic [2*DW-1:0] wide;
        r    = cur;
        wide = {b, cur[DW-1:0]};
        case (o)
            ADDR_LOAD_LO: r[DW-1:0] = b;
            ADDR_LOAD_HI: r = wide[AW-1:0];
            ADDR_INC:     r = cur + ADDR_ONE;
            default:      r = cur;
        endcase
        return r;
    endfunction

    always_comb begin
        pc_d = pc_q;
        dp_d = dp_q;
        if (addr_sel == ADDR_SEL_PC) pc_d = addr_update(pc_q, addr_reg_op, bus_data_in);
        else                         dp_d = addr_update(dp_q, addr_reg_op, bus_data_in);
    end

    assign sel_reg = (addr_sel == ADDR_SEL_DATA) ? dp_q : pc_q;

    // Gated by reset so the bus reads all-zero while reset is held,
    // regardless of addr_sel.
    always_comb begin
        addr_full            = '0;
        addr_full[AW-1:0]    = sel_reg;
        addr_full[24]        = (addr_sel == ADDR_SEL_DATA);
        eng.addr_out         = reset ? addr_full : 25'd0;
    end

    assign is_read  = (op == MEM_READ);
    assign is_write = (op == MEM_WRITE);

`ifdef MEM_CTRL_BURST_EN
    assign load_on_burst_reg = ((addr_reg_op == ADDR_LOAD_LO) || (addr_reg_op == ADDR_LOAD_HI))
                               && (addr_sel == last_sel_q);
    assign burst_continue    = (op == last_op_q) && (addr_sel == last_sel_q)
                               && (sel_reg == last_addr_q + ADDR_ONE);
`endif

    always_comb begin
        state_d    = state_q;
        start_rd_d = 1'b0;
        start_wr_d = 1'b0;
        stop_d     = 1'b0;
        done_d     = 1'b0;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef MEM_CTRL_BURST_EN
        stall_d     = stall_q;
        last_op_d   = last_op_q;
        last_sel_d  = last_sel_q;
        last_addr_d = last_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (is_read || is_write) begin
`ifdef MEM_CTRL_BURST_EN
                    last_op_d   = op;
                    last_sel_d  = addr_sel;
                    last_addr_d = sel_reg;
`endif
                    if (is_read) begin
                        start_rd_d = 1'b1;
                        state_d    = ST_RD_WAIT;
                    end else begin
                        wdata_d    = bus_data_in;
                        start_wr_d = 1'b1;
                        state_d    = ST_WR_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                // data_req is deliberately ignored here
                if (eng.data_ready) begin
                    rdata_d = eng.data_in;
                    done_d  = 1'b1;
`ifdef MEM_CTRL_BURST_EN
                    stall_d = 1'b1;
`else
                    stop_d  = 1'b1;
`endif
                    state_d = ST_ACK;
                end
            end
            ST_WR_WAIT: begin
                if (eng.data_req) begin
                    done_d  = 1'b1;
`ifdef MEM_CTRL_BURST_EN
                    stall_d = 1'b1;
`else
                    stop_d  = 1'b1;
`endif
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // Level-held op must drop to NOP before the next access.
                if (!is_read && !is_write) begin
`ifdef MEM_CTRL_BURST_EN
                    state_d = ST_HOLD;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef MEM_CTRL_BURST_EN
            ST_HOLD: begin
                if (load_on_burst_reg) begin
                    stop_d  = 1'b1;
                    stall_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (is_read || is_write) begin
                    stall_d = 1'b0;
                    if (burst_continue) begin
                        last_addr_d = sel_reg;
                        if (is_write) begin
                            wdata_d = bus_data_in;
                            state_d = ST_WR_WAIT;
                        end else begin
                            state_d = ST_RD_WAIT;
                        end
                    end else begin
                        // Close the burst; IDLE issues a fresh start next cycle.
                        stop_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            dp_q       <= '0;
            start_rd_q <= 1'b0;
            start_wr_q <= 1'b0;
            stop_q     <= 1'b0;
            done_q     <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef MEM_CTRL_BURST_EN
            stall_q     <= 1'b0;
            last_op_q   <= MEM_NOP;
            last_sel_q  <= ADDR_SEL_PC;
            last_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dp_q       <= dp_d;
            start_rd_q <= start_rd_d;
            start_wr_q <= start_wr_d;
            stop_q     <= stop_d;
            done_q     <= done_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
`ifdef MEM_CTRL_BURST_EN
            stall_q     <= stall_d;
            last_op_q   <= last_op_d;
            last_sel_q  <= last_sel_d;
            last_addr_q <= last_addr_d;
`endif
        end
    end

    assign eng.start_read  = start_rd_q;
    assign eng.start_write = start_wr_q;
    assign eng.stop_txn    = stop_q;
    assign eng.data_out    = wdata_q;
    assign bus_data_out    = rdata_q;
    assign op_done_out     = done_q;
`ifdef MEM_CTRL_BURST_EN
    assign eng.stall_txn   = stall_q;
`else
    assign eng.stall_txn   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller
//
// Purpose: directed-vector bench for mem_controller (default build).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_mem_controller;
    import mem_controller_pkg::*;

    logic              clock;
    logic              reset;
    addr_register_op_e addr_reg_op;
    addr_sel_e         addr_sel;
    mem_op_e           op;
    logic [7:0]        bus_data_in;
    logic [7:0]        bus_data_out;
    logic              op_done_out;

    int n_vec;
    int n_err;

    mem_controller_if #(.DATA_BUS_WIDTH(8)) eng ();

    mem_controller #(
        .DATA_BUS_WIDTH(8),
        .ADDRESS_WIDTH (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .addr_reg_op (addr_reg_op),
        .addr_sel    (addr_sel),
        .op          (op),
        .bus_data_in (bus_data_in),
        .bus_data_out(bus_data_out),
        .op_done_out (op_done_out),
        .eng         (eng.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".start_read"},  {31'd0, eng.start_read},  32'd0);
        check({tag, ".start_write"}, {31'd0, eng.start_write}, 32'd0);
        check({tag, ".stop_txn"},    {31'd0, eng.stop_txn},    32'd0);
        check({tag, ".op_done"},     {31'd0, op_done_out},     32'd0);
        check({tag, ".stall_txn"},   {31'd0, eng.stall_txn},   32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset with arbitrary active inputs
        reset          = 1'b0;
        addr_reg_op    = ADDR_INC;
        addr_sel       = ADDR_SEL_DATA;
        op             = MEM_READ;
        bus_data_in    = 8'hFF;
        eng.data_in    = 8'hEE;
        eng.data_req   = 1'b1;
        eng.data_ready = 1'b1;
        #12;
        check_idle_outputs("rst");
        check("rst.addr_out", {7'd0, eng.addr_out}, 32'h0000000);
        check("rst.bus_data_out", {24'd0, bus_data_out}, 32'h00);
        check("rst.data_out", {24'd0, eng.data_out}, 32'h00);

        @(posedge clock);
        #1;
        addr_reg_op    = ADDR_NOP;
        addr_sel       = ADDR_SEL_PC;
        op             = MEM_NOP;
        bus_data_in    = 8'h00;
        eng.data_in    = 8'h00;
        eng.data_req   = 1'b0;
        eng.data_ready = 1'b0;
        reset          = 1'b1;
        tick();
        check_idle_outputs("post_rst");

        // Address load on PC
        addr_reg_op = ADDR_LOAD_LO; bus_data_in = 8'h34; tick();
        check("pc.lo", {7'd0, eng.addr_out}, 32'h0000034);
        addr_reg_op = ADDR_LOAD_HI; bus_data_in = 8'h12; tick();
        addr_reg_op = ADDR_NOP;
        check("pc.hi", {7'd0, eng.addr_out}, 32'h0001234);
        addr_sel = ADDR_SEL_DATA; #1;
        check("data.sel", {7'd0, eng.addr_out}, 32'h1000000);

        // Increment wrap on DATA
        addr_reg_op = ADDR_LOAD_LO; bus_data_in = 8'hFF; tick();
        addr_reg_op = ADDR_LOAD_HI; bus_data_in = 8'hFF; tick();
        addr_reg_op = ADDR_NOP;
        check("data.ffff", {7'd0, eng.addr_out}, 32'h100FFFF);
        addr_reg_op = ADDR_INC; tick();
        addr_reg_op = ADDR_NOP;
        check("data.wrap", {7'd0, eng.addr_out}, 32'h1000000);
        addr_sel = ADDR_SEL_PC; #1;
        check("pc.keep", {7'd0, eng.addr_out}, 32'h0001234);
        addr_reg_op = ADDR_INC; tick();
        addr_reg_op = ADDR_NOP;
        check("pc.inc", {7'd0, eng.addr_out}, 32'h0001235);

        // Read
        op = MEM_READ; tick();
        check("rd.start", {31'd0, eng.start_read}, 32'd1);
        check("rd.no_wr", {31'd0, eng.start_write}, 32'd0);
        eng.data_req = 1'b1; tick();
        eng.data_req = 1'b0;
        check("rd.start_drop", {31'd0, eng.start_read}, 32'd0);
        check("rd.req_ignored", {31'd0, op_done_out}, 32'd0);
        eng.data_in = 8'hA5; eng.data_ready = 1'b1; tick();
        eng.data_ready = 1'b0; eng.data_in = 8'h00;
        check("rd.stop", {31'd0, eng.stop_txn}, 32'd1);
        check("rd.done", {31'd0, op_done_out}, 32'd1);
        check("rd.data", {24'd0, bus_data_out}, 32'hA5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd.hold.start", {31'd0, eng.start_read}, 32'd0);
            check("rd.hold.done", {31'd0, op_done_out}, 32'd0);
            check("rd.hold.stop", {31'd0, eng.stop_txn}, 32'd0);
        end
        op = MEM_NOP; tick();
        check("rd.keep", {24'd0, bus_data_out}, 32'hA5);

        // Write
        bus_data_in = 8'h5A; op = MEM_WRITE; tick();
        bus_data_in = 8'h00;
        check("wr.data_out", {24'd0, eng.data_out}, 32'h5A);
        check("wr.start", {31'd0, eng.start_write}, 32'd1);
        check("wr.no_rd", {31'd0, eng.start_read}, 32'd0);
        eng.data_ready = 1'b1; tick();
        eng.data_ready = 1'b0;
        check("wr.start_drop", {31'd0, eng.start_write}, 32'd0);
        check("wr.ready_ignored", {31'd0, op_done_out}, 32'd0);
        eng.data_req = 1'b1; tick();
        eng.data_req = 1'b0;
        check("wr.stop", {31'd0, eng.stop_txn}, 32'd1);
        check("wr.done", {31'd0, op_done_out}, 32'd1);
        tick();
        check("wr.stop_drop", {31'd0, eng.stop_txn}, 32'd0);
        check("wr.data_hold", {24'd0, eng.data_out}, 32'h5A);
        op = MEM_NOP; tick();

        // data_ready in IDLE must be ignored
        eng.data_in = 8'h33; eng.data_ready = 1'b1; tick();
        eng.data_ready = 1'b0;
        check("idle.ready_done", {31'd0, op_done_out}, 32'd0);
        check("idle.ready_data", {24'd0, bus_data_out}, 32'hA5);
        tick();
        check_idle_outputs("idle");

        // Reset in RD_WAIT
        op = MEM_READ; tick();
        check("rr.start", {31'd0, eng.start_read}, 32'd1);
        op = MEM_NOP; tick();
        reset = 1'b0; #1;
        check_idle_outputs("rr.in_rst");
        check("rr.rdata", {24'd0, bus_data_out}, 32'h00);
        check("rr.wdata", {24'd0, eng.data_out}, 32'h00);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rr.no_stop", {31'd0, eng.stop_txn}, 32'd0);
            check("rr.no_done", {31'd0, op_done_out}, 32'd0);
        end
        check("rr.addr", {7'd0, eng.addr_out}, 32'h0000000);

        // Read after reset; data_req with data_ready in RD_WAIT
        op = MEM_READ; tick();
        check("rr2.start", {31'd0, eng.start_read}, 32'd1);
        op = MEM_NOP;
        eng.data_in = 8'h3C; eng.data_ready = 1'b1; eng.data_req = 1'b1; tick();
        eng.data_ready = 1'b0; eng.data_req = 1'b0; eng.data_in = 8'h00;
        check("rr2.done", {31'd0, op_done_out}, 32'd1);
        check("rr2.stop", {31'd0, eng.stop_txn}, 32'd1);
        check("rr2.data", {24'd0, bus_data_out}, 32'h3C);
        tick();
        tick();
        check_idle_outputs("rr2.end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
